// File: rtl/serial_cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator.
// State encoding and comparator chain seed values.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  localparam logic E_SEED = 1'b1;
  localparam logic G_SEED = 1'b0;

endpackage

// File: rtl/cmp_bit_cell.sv
// One equal/greater cell of an MSB-first magnitude compare chain.
// Purely combinational; the caller holds e/g between bits.
module cmp_bit_cell (
  input  logic a_bit,
  input  logic b_bit,
  input  logic e_in,
  input  logic g_in,
  output logic e_out,
  output logic g_out
);

  assign e_out = e_in & ~(a_bit ^ b_bit);
  assign g_out = g_in | (e_in & a_bit & ~b_bit);

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned compare: one cmp_bit_cell fed MSB-first by shifters.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish at the first differing bit.
module serial_mag_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [CW-1:0]    cnt_q;
  logic             e_q;
  logic             g_q;
  logic             busy_q;
  logic             done_q;
  logic             eq_q;
  logic             gt_q;
  logic             lt_q;

  logic e_d;
  logic g_d;
  logic fin;

  cmp_bit_cell u_cell (
    .a_bit (sa_q[WIDTH-1]),
    .b_bit (sb_q[WIDTH-1]),
    .e_in  (e_q),
    .g_in  (g_q),
    .e_out (e_d),
    .g_out (g_d)
  );

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign fin = (cnt_q == '0) | ~e_d;
`else
  assign fin = (cnt_q == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      e_q     <= E_SEED;
      g_q     <= G_SEED;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            e_q     <= E_SEED;
            g_q     <= G_SEED;
            cnt_q   <= CNT_INIT;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_SHIFT: begin
          e_q   <= e_d;
          g_q   <= g_d;
          sa_q  <= {sa_q[WIDTH-2:0], 1'b0};
          sb_q  <= {sb_q[WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q - CW'(1);
          if (fin) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            eq_q    <= e_d;
            gt_q    <= g_d;
            lt_q    <= ~e_d & ~g_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign eq   = eq_q;
  assign gt   = gt_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed + random checks of serial_mag_comparator against a reference model.
// Covers reset, latency, held results, back-to-back and mid-op reset.
module tb_serial_mag_comparator;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         eq;
  logic         gt;
  logic         lt;

  int total;
  int bad;
  logic [2:0] prev_res;

  serial_mag_comparator #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .eq    (eq),
    .gt    (gt),
    .lt    (lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {eq,gt,lt} from plain integer comparison.
  function automatic logic [2:0] ref_res(input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    int unsigned ux = x;
    int unsigned uy = y;
    return {ux == uy, ux > uy, ux < uy};
  endfunction

  // Edges from start edge to done edge.
  function automatic int ref_lat(input logic [W-1:0] x,
                                 input logic [W-1:0] y);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int j = 0; j < W; j++)
      if (x[W-1-j] != y[W-1-j]) return j + 1;
`endif
    return W;
  endfunction

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= W + 3; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  // Runs one op; start is dropped after acceptance, operands scrambled.
  task automatic run_op(input string tag, input logic [W-1:0] x,
                        input logic [W-1:0] y);
    int lat;
    start = 1'b1; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_held"}, {eq, gt, lt}, prev_res);
    wait_done(lat);
    chk({tag, "_lat"}, lat, ref_lat(x, y));
    chk({tag, "_res"}, {eq, gt, lt}, ref_res(x, y));
    chk({tag, "_busy0"}, busy, 0);
    prev_res = ref_res(x, y);
  endtask

  initial begin
    int lat;
    logic [W-1:0] x1, y1, x2, y2;
    total = 0;
    bad = 0;
    prev_res = 3'b000;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold", {busy, done, eq, gt, lt}, 5'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("rst_idle", {busy, done, eq, gt, lt}, 5'b0);
    end

    run_op("eqA5", 8'hA5, 8'hA5);
    run_op("gt80", 8'h80, 8'h7F);
    run_op("lt12", 8'h12, 8'h13);

    for (int i = 0; i < 20; i++) begin
      x1 = W'($urandom);
      y1 = (i % 4 == 0) ? x1 : W'($urandom);
      run_op("rnd", x1, y1);
    end

    // Back-to-back with start held high through the first operation.
    x1 = 8'h3C; y1 = 8'h3D; x2 = 8'hF0; y2 = 8'h0F;
    start = 1'b1; a = x1; b = y1;
    @(posedge clk); #1;
    a = W'($urandom); b = W'($urandom);
    wait_done(lat);
    chk("b2b1_lat", lat, ref_lat(x1, y1));
    chk("b2b1_res", {eq, gt, lt}, ref_res(x1, y1));
    a = x2; b = y2;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    chk("b2b2_busy", busy, 1);
    wait_done(lat);
    chk("b2b2_lat", lat, ref_lat(x2, y2));
    chk("b2b2_res", {eq, gt, lt}, ref_res(x2, y2));
    prev_res = ref_res(x2, y2);

    // Reset in the middle of an equal-length shift.
    start = 1'b1; a = 8'hFF; b = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst", {busy, done, eq, gt, lt}, 5'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    prev_res = 3'b000;
    for (int k = 0; k < W + 2; k++) begin
      @(posedge clk); #1;
      chk("mid_rst_nodone", {busy, done}, 2'b00);
    end
    run_op("post_rst", 8'h01, 8'h02);
    chk("post_rst_lt", lt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
